// File: rtl/hamming_serial_decoder_if.sv
// Bus bundle for the serial Hamming decoder: bit-stream input side plus the
// word-level output buffer with its valid/ready handshake and status flags.
interface hamming_serial_decoder_if #(
  parameter int R = 3
);
  localparam int N = (1 << R) - 1;
  localparam int K = N - R;

  logic         in_bit;
  logic         in_valid;
  logic         frame_start;
  logic [K-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic [R-1:0] out_syndrome;
  logic         err_corrected;
  logic         err_uncorr;
  logic         overrun;

  // Bit source and word consumer.
  modport master (
    output in_bit, in_valid, frame_start, out_ready,
    input  out_data, out_valid, out_syndrome, err_corrected, err_uncorr, overrun
  );

  // The decoder itself.
  modport slave (
    input  in_bit, in_valid, frame_start, out_ready,
    output out_data, out_valid, out_syndrome, err_corrected, err_uncorr, overrun
  );
endinterface

// File: rtl/hamming_serial_decoder.sv
// Serial Hamming(2^R-1, 2^R-1-R) decoder with optional SECDED overall parity.
// Collects one frame bit per in_valid strobe, decodes in a single DECODE
// cycle and parks the result in a one-entry output buffer.
//
// Handshake: a word moves to the consumer on any cycle where ena, out_valid
// and out_ready are all high at the rising clock edge; out_data and the flags
// are stable while out_valid is high and not yet accepted.
module hamming_serial_decoder #(
  parameter int R      = 3,
  parameter bit SECDED = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  hamming_serial_decoder_if.slave  bus,
  output logic [1:0]               dbg_state
);

  localparam int N    = (1 << R) - 1;
  localparam int K    = N - R;
  localparam int FLEN = N + (SECDED ? 1 : 0);
  localparam int CW   = $clog2(FLEN + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECV   = 2'd1,
    DECODE = 2'd2
  } state_t;

  // Code position of the k-th data bit (k = 0 is the lowest non-power-of-two position).
  function automatic int data_pos(input int k);
    int seen;
    seen = 0;
    for (int p = 1; p <= N; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (seen == k) return p;
        seen++;
      end
    end
    return 1;
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [FLEN-1:0] frame_q;
  logic            cap_en;
  logic [CW-1:0]   cap_idx;
  logic            decode_fire;

  logic [R-1:0]    syn_c;
  logic            par_c;
  logic            flip_en;
  logic [N-1:0]    code_c;
  logic [K-1:0]    data_c;
  logic            corr_c;
  logic            uncorr_c;

  logic [K-1:0]    data_q;
  logic [R-1:0]    syn_q;
  logic            corr_q;
  logic            uncorr_q;
  logic            valid_q;
  logic            overrun_q;

  // Frame sequencing: state register and bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else if (ena) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; frame_start always restarts at code position 1.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cap_en      = 1'b0;
    cap_idx     = cnt_q;
    decode_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && bus.frame_start) begin
          cap_en  = 1'b1;
          cap_idx = '0;
          cnt_d   = CW'(1);
          state_d = RECV;
        end
      end
      RECV: begin
        if (bus.in_valid) begin
          cap_en = 1'b1;
          if (bus.frame_start) begin
            cap_idx = '0;
            cnt_d   = CW'(1);
          end else if (cnt_q == CW'(FLEN - 1)) begin
            cnt_d   = '0;
            state_d = DECODE;
          end else begin
            cnt_d   = cnt_q + CW'(1);
          end
        end
      end
      DECODE: begin
        decode_fire = 1'b1;
        if (bus.in_valid && bus.frame_start) begin
          cap_en  = 1'b1;
          cap_idx = '0;
          cnt_d   = CW'(1);
          state_d = RECV;
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Frame storage: bit index i holds code position i+1 (overall parity last).
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q <= '0;
    end else if (ena) begin
      for (int i = 0; i < FLEN; i++) begin
        if (cap_en && (cap_idx == CW'(i))) frame_q[i] <= bus.in_bit;
      end
    end
  end

  // Syndrome, overall parity, correction and data extraction.
  always_comb begin
    syn_c = '0;
    for (int p = 1; p <= N; p++) begin
      if (frame_q[p-1]) syn_c = syn_c ^ R'(p);
    end
    par_c   = SECDED ? ^frame_q : 1'b0;
    // With SECDED a nonzero syndrome is only trusted when overall parity is odd.
    flip_en = (syn_c != '0) && (SECDED ? par_c : 1'b1);
    code_c  = frame_q[N-1:0];
    for (int p = 1; p <= N; p++) begin
      if (flip_en && (syn_c == R'(p))) code_c[p-1] = ~code_c[p-1];
    end
    data_c = '0;
    for (int k = 0; k < K; k++) begin
      data_c[k] = code_c[data_pos(k) - 1];
    end
    // Odd overall parity alone means the parity bit itself was hit: still a corrected case.
    corr_c   = SECDED ? par_c : (syn_c != '0);
    uncorr_c = SECDED && (syn_c != '0) && !par_c;
  end

  // One-entry output buffer; a decode into a full, unpopped buffer is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= '0;
      syn_q     <= '0;
      corr_q    <= 1'b0;
      uncorr_q  <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else if (ena) begin
      if (decode_fire) begin
        if (!valid_q || bus.out_ready) begin
          data_q   <= data_c;
          syn_q    <= syn_c;
          corr_q   <= corr_c;
          uncorr_q <= uncorr_c;
          valid_q  <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && bus.out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_data      = data_q;
  assign bus.out_syndrome  = syn_q;
  assign bus.err_corrected = corr_q;
  assign bus.err_uncorr    = uncorr_q;
  assign bus.out_valid     = valid_q;
  assign bus.overrun       = overrun_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_hamming_serial_decoder.sv
// Bench for hamming_serial_decoder: an R=3 SECDED instance and an R=4 SEC-only
// instance, each with its own bus, driver tasks and expected-word queue.
module tb_hamming_serial_decoder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic ena;
  always #5 clk = ~clk;

  hamming_serial_decoder_if #(.R(3)) bus_a ();
  hamming_serial_decoder_if #(.R(4)) bus_b ();
  logic [1:0] dbg_a, dbg_b;

  hamming_serial_decoder #(.R(3), .SECDED(1'b1)) dut_a (
    .clk(clk), .rst(rst), .ena(ena), .bus(bus_a), .dbg_state(dbg_a)
  );
  hamming_serial_decoder #(.R(4), .SECDED(1'b0)) dut_b (
    .clk(clk), .rst(rst), .ena(ena), .bus(bus_b), .dbg_state(dbg_b)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];
  int ready_mode = 1;  // 0: hold off, 1: always ready, 2: random

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] encode(input int r, input logic [15:0] d);
    int n;
    int j;
    logic [15:0] c;
    logic pb;
    n = (1 << r) - 1;
    j = 0;
    c = '0;
    for (int p = 1; p <= n; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p-1] = d[j];
        j++;
      end
    end
    for (int i = 0; i < r; i++) begin
      pb = 1'b0;
      for (int p = 1; p <= n; p++) begin
        if (((p >> i) & 1) == 1 && p != (1 << i)) pb = pb ^ c[p-1];
      end
      c[(1 << i) - 1] = pb;
    end
    return c;
  endfunction

  function automatic logic [15:0] extract(input int r, input logic [16:0] f);
    int n;
    int j;
    logic [15:0] d;
    n = (1 << r) - 1;
    j = 0;
    d = '0;
    for (int p = 1; p <= n; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[j] = f[p-1];
        j++;
      end
    end
    return d;
  endfunction

  // Frame bits in transmit order; e1/e2 are 1-based positions to invert (0 = none).
  function automatic logic [16:0] build(input int which, input logic [15:0] d, input int e1, input int e2);
    int r;
    int n;
    logic [15:0] c;
    logic [16:0] f;
    r = (which == 0) ? 3 : 4;
    n = (1 << r) - 1;
    c = encode(r, d);
    f = {1'b0, c};
    if (which == 0) f[n] = ^c;
    if (e1 > 0) f[e1-1] = ~f[e1-1];
    if (e2 > 0) f[e2-1] = ~f[e2-1];
    return f;
  endfunction

  function automatic logic [31:0] expect_word(input int which, input logic [15:0] d, input int e1, input int e2);
    int r;
    int n;
    int e;
    logic [3:0] syn;
    logic corr;
    logic unc;
    logic [15:0] dd;
    logic [16:0] f;
    r    = (which == 0) ? 3 : 4;
    n    = (1 << r) - 1;
    syn  = '0;
    corr = 1'b0;
    unc  = 1'b0;
    dd   = d;
    if ((e1 > 0) != (e2 > 0)) begin
      e    = (e1 > 0) ? e1 : e2;
      corr = 1'b1;
      syn  = (e <= n) ? 4'(e) : 4'd0;
    end else if (e1 > 0) begin
      syn = ((e1 <= n) ? 4'(e1) : 4'd0) ^ ((e2 <= n) ? 4'(e2) : 4'd0);
      unc = 1'b1;
      f   = build(which, d, e1, e2);
      dd  = extract(r, f);
    end
    if (which == 0) return {21'b0, unc, corr, syn[2:0], dd[3:0]};
    return {15'b0, unc, corr, syn[3:0], dd[10:0]};
  endfunction

  // ---------------- driver tasks ----------------
  always @(posedge clk) begin
    #1;
    bus_a.out_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
    bus_b.out_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
  end

  task automatic drive(input int which, input logic v, input logic b, input logic fs);
    @(posedge clk);
    #1;
    if (which == 0) begin
      bus_a.in_valid = v; bus_a.in_bit = b; bus_a.frame_start = fs;
    end else begin
      bus_b.in_valid = v; bus_b.in_bit = b; bus_b.frame_start = fs;
    end
  endtask

  task automatic send_frame(input int which, input logic [15:0] d, input int e1, input int e2, input bit push);
    logic [16:0] f;
    int flen;
    f    = build(which, d, e1, e2);
    flen = (which == 0) ? 8 : 15;
    if (push) begin
      if (which == 0) exp_a.push_back(expect_word(which, d, e1, e2));
      else            exp_b.push_back(expect_word(which, d, e1, e2));
    end
    for (int i = 0; i < flen; i++) drive(which, 1'b1, f[i], i == 0);
    drive(which, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_drain(input int which);
    for (int i = 0; i < 300; i++) begin
      if (which == 0 && exp_a.size() == 0 && !bus_a.out_valid) return;
      if (which == 1 && exp_b.size() == 0 && !bus_b.out_valid) return;
      @(negedge clk);
    end
    if (which == 0) check("drain_a_timeout", {exp_a.size(), bus_a.out_valid}, 32'd0);
    else            check("drain_b_timeout", {exp_b.size(), bus_b.out_valid}, 32'd0);
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (ena && bus_a.out_valid && bus_a.out_ready) begin
      if (exp_a.size() == 0) begin
        check("a_unexpected_word", {23'b0, bus_a.out_data}, 32'hFFFF_FFFF);
      end else begin
        check("a_word", {21'b0, bus_a.err_uncorr, bus_a.err_corrected, bus_a.out_syndrome, bus_a.out_data},
              exp_a.pop_front());
      end
    end
    if (ena && bus_b.out_valid && bus_b.out_ready) begin
      if (exp_b.size() == 0) begin
        check("b_unexpected_word", {21'b0, bus_b.out_data}, 32'hFFFF_FFFF);
      end else begin
        check("b_word", {15'b0, bus_b.err_uncorr, bus_b.err_corrected, bus_b.out_syndrome, bus_b.out_data},
              exp_b.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [16:0] f;
    int e1;
    int e2;
    int nerr;
    bus_a.in_valid = 1'b0; bus_a.in_bit = 1'b0; bus_a.frame_start = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_bit = 1'b0; bus_b.frame_start = 1'b0;
    rst = 1'b1;
    ena = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid_a", bus_a.out_valid, 32'd0);
    check("rst_data_a", bus_a.out_data, 32'd0);
    check("rst_syn_a", bus_a.out_syndrome, 32'd0);
    check("rst_flags_a", {bus_a.err_corrected, bus_a.err_uncorr, bus_a.overrun}, 32'd0);
    check("rst_state_a", dbg_a, 32'd0);
    check("rst_valid_b", bus_b.out_valid, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Clean frame with latency check: DECODE in t+1, out_valid from t+2.
    send_frame(0, 16'b1011, 0, 0, 1'b1);
    @(negedge clk);
    check("lat_decode_state", dbg_a, 32'd2);
    check("lat_not_yet_valid", bus_a.out_valid, 32'd0);
    @(negedge clk);
    check("lat_valid", bus_a.out_valid, 32'd1);
    wait_drain(0);

    // Single error at position 6, double error at 3 and 5.
    send_frame(0, 16'b1011, 6, 0, 1'b1);
    wait_drain(0);
    send_frame(0, 16'b1011, 3, 5, 1'b1);
    wait_drain(0);
    // Error on the overall parity bit alone.
    send_frame(0, 16'b0110, 8, 0, 1'b1);
    wait_drain(0);

    // Overrun: consumer stalled, second word dropped.
    ready_mode = 0;
    @(posedge clk);
    send_frame(0, 16'b1011, 0, 0, 1'b1);
    send_frame(0, 16'b0101, 0, 0, 1'b0);
    repeat (3) @(negedge clk);
    check("ovr_held_valid", bus_a.out_valid, 32'd1);
    check("ovr_held_data", bus_a.out_data, 32'b1011);
    check("ovr_sticky", bus_a.overrun, 32'd1);
    ready_mode = 1;
    wait_drain(0);
    check("ovr_still_set", bus_a.overrun, 32'd1);

    // Restart mid-frame: 4 stray bits then a full clean frame.
    f = build(0, 16'b0110, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 1'b1, ~f[i], i == 0);
    send_frame(0, 16'b1011, 0, 0, 1'b1);
    wait_drain(0);

    // Clock enable low for three strobes inside a frame: those bits are ignored.
    f = build(0, 16'b1100, 0, 0);
    exp_a.push_back(expect_word(0, 16'b1100, 0, 0));
    for (int i = 0; i < 3; i++) drive(0, 1'b1, f[i], i == 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'b1, 1'($urandom_range(0, 1)), 1'b1);
      ena = 1'b0;
    end
    for (int i = 3; i < 8; i++) begin
      drive(0, 1'b1, f[i], 1'b0);
      ena = 1'b1;
    end
    drive(0, 1'b0, 1'b0, 1'b0);
    wait_drain(0);

    // Random frames with 0, 1 or 2 errors under random back-pressure.
    ready_mode = 2;
    for (int t = 0; t < 24; t++) begin
      nerr = $urandom_range(0, 2);
      e1   = (nerr >= 1) ? $urandom_range(1, 8) : 0;
      e2   = 0;
      if (nerr == 2) begin
        e2 = $urandom_range(1, 7);
        if (e2 >= e1) e2++;
      end
      send_frame(0, 16'($urandom_range(0, 15)), e1, e2, 1'b1);
      wait_drain(0);
    end

    // Reset mid-frame drops both the partial frame and the held word.
    ready_mode = 0;
    @(posedge clk);
    send_frame(0, 16'b0110, 0, 0, 1'b0);
    repeat (2) @(negedge clk);
    check("prerst_held", bus_a.out_valid, 32'd1);
    f = build(0, 16'b1011, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 1'b1, f[i], i == 0);
    drive(0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 5; i < 8; i++) drive(0, 1'b1, f[i], 1'b0);
    drive(0, 1'b0, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    check("postrst_valid", bus_a.out_valid, 32'd0);
    check("postrst_state", dbg_a, 32'd0);
    check("postrst_overrun", bus_a.overrun, 32'd0);
    check("postrst_data", bus_a.out_data, 32'd0);
    ready_mode = 1;

    // R=4 SEC-only instance: clean frame then random single errors.
    send_frame(1, 16'h05A3, 0, 0, 1'b1);
    wait_drain(1);
    for (int t = 0; t < 12; t++) begin
      e1 = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 15);
      send_frame(1, 16'($urandom_range(0, 2047)), e1, 0, 1'b1);
      wait_drain(1);
    end
    check("b_no_uncorr_flag", bus_b.err_uncorr, 32'd0);

    repeat (4) @(negedge clk);
    check("a_queue_empty", exp_a.size(), 32'd0);
    check("b_queue_empty", exp_b.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
